// File: rtl/la_iopocseq_if.sv
// la_iopocseq_if: request/config and ring-control bundle between the power manager and the IO ring sequencer
interface la_iopocseq_if #(
  parameter int N    = 4,
  parameter int CFGW = 16,
  parameter int DLYW = 8
);
  logic            en;
  logic [DLYW-1:0] dly;
  logic [CFGW-1:0] cfg_in;
  logic [N-1:0]    ring_en;
  logic            iso;
  logic [CFGW-1:0] cfg;
  logic            ready;
  logic            busy;
  modport master(output en, dly, cfg_in, input ring_en, iso, cfg, ready, busy);
  modport slave(input en, dly, cfg_in, output ring_en, iso, cfg, ready, busy);
endinterface

// File: rtl/la_iopocseq.sv
// la_iopocseq: power-on sequencer enabling IO ring segments one by one, releasing isolation once settled
module la_iopocseq #(
  parameter int N    = 4,
  parameter int CFGW = 16,
  parameter int DLYW = 8
) (
  input logic         clk,
  input logic         nreset,
  la_iopocseq_if.slave bus
);
  localparam int IW = N > 1 ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);
  typedef enum logic [2:0] {OFF, RAMP, SETTLE, ON, DOWN} state_t;
  state_t          r_state, w_state;
  logic [DLYW-1:0] r_cnt, w_cnt;
  logic [IW-1:0]   r_idx, w_idx;
  logic [N-1:0]    r_ring_en, w_ring_en;
  logic            r_iso, r_ready, r_busy;
  logic [CFGW-1:0] r_cfg;
  logic            w_zero;
  assign w_zero = r_cnt == '0;
  // r_idx in RAMP equals the number of segments already enabled
  always_comb begin
    w_state   = r_state;
    w_cnt     = r_cnt;
    w_idx     = r_idx;
    w_ring_en = r_ring_en;
    case (r_state)
      OFF: if (bus.en) begin
        w_state = RAMP;
        w_idx   = '0;
        w_cnt   = bus.dly;
      end
      RAMP: if (!bus.en) begin
        w_state = r_idx == '0 ? OFF : DOWN;
        w_idx   = r_idx == '0 ? '0 : r_idx - 1'b1;
        w_cnt   = bus.dly;
      end else if (!w_zero) begin
        w_cnt = r_cnt - 1'b1;
      end else begin
        w_ring_en[r_idx] = 1'b1;
        w_cnt            = bus.dly;
        w_state          = r_idx == LAST ? SETTLE : RAMP;
        w_idx            = r_idx == LAST ? r_idx : r_idx + 1'b1;
      end
      SETTLE: if (!bus.en) begin
        w_state = DOWN;
        w_idx   = LAST;
        w_cnt   = bus.dly;
      end else begin
        w_state = w_zero ? ON : SETTLE;
        w_cnt   = w_zero ? r_cnt : r_cnt - 1'b1;
      end
      ON: if (!bus.en) begin
        w_state = DOWN;
        w_idx   = LAST;
        w_cnt   = bus.dly;
      end
      DOWN: if (!w_zero) begin
        w_cnt = r_cnt - 1'b1;
      end else begin
        w_ring_en[r_idx] = 1'b0;
        w_cnt            = bus.dly;
        w_state          = r_idx == '0 ? OFF : DOWN;
        w_idx            = r_idx == '0 ? r_idx : r_idx - 1'b1;
      end
      default: ;
    endcase
  end
  // status outputs are registered from the next state so they line up with it
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state   <= OFF;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_ring_en <= '0;
      r_iso     <= 1'b1;
      r_ready   <= 1'b0;
      r_busy    <= 1'b0;
      r_cfg     <= '0;
    end else begin
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      r_idx     <= w_idx;
      r_ring_en <= w_ring_en;
      r_iso     <= w_state != ON;
      r_ready   <= w_state == ON;
      r_busy    <= w_state inside {RAMP, SETTLE, DOWN};
      r_cfg     <= w_state == ON ? bus.cfg_in : '0;
    end
  end
  assign bus.ring_en = r_ring_en;
  assign bus.iso     = r_iso;
  assign bus.ready   = r_ready;
  assign bus.busy    = r_busy;
  assign bus.cfg     = r_cfg;
endmodule

// File: tb/tb_la_iopocseq.sv
// tb_la_iopocseq: directed scenarios for la_iopocseq, checked every cycle against a step-timing model
module tb_la_iopocseq;
  logic clk = 1'b0;
  logic nreset = 1'b1;
  int e = 0;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  always @(posedge clk) e <= e + 1;

  la_iopocseq_if #(.N(4), .CFGW(16), .DLYW(8)) bus();
  la_iopocseq #(.N(4), .CFGW(16), .DLYW(8)) dut(.clk(clk), .nreset(nreset), .bus(bus));

  // model: mode 0=off 1=up 2=settle 3=on 4=down; k = segments on; t counts edges into a step of len edges
  int m_mode = 0, m_k = 0, m_t = 0, m_len = 1;
  logic [15:0] m_cfg = '0;
  always @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      m_mode = 0; m_k = 0; m_t = 0; m_len = 1; m_cfg = '0;
    end else begin
      case (m_mode)
        0: if (bus.en) begin m_mode = 1; m_k = 0; m_t = 0; m_len = int'(bus.dly) + 1; end
        1: if (!bus.en) begin
             m_mode = m_k == 0 ? 0 : 4; m_t = 0; m_len = int'(bus.dly) + 1;
           end else begin
             m_t++;
             if (m_t == m_len) begin
               m_k++; m_t = 0; m_len = int'(bus.dly) + 1;
               if (m_k == 4) m_mode = 2;
             end
           end
        2: if (!bus.en) begin
             m_mode = 4; m_t = 0; m_len = int'(bus.dly) + 1;
           end else begin
             m_t++;
             if (m_t == m_len) m_mode = 3;
           end
        3: if (!bus.en) begin m_mode = 4; m_t = 0; m_len = int'(bus.dly) + 1; end
        4: begin
             m_t++;
             if (m_t == m_len) begin
               m_k--; m_t = 0; m_len = int'(bus.dly) + 1;
               if (m_k == 0) m_mode = 0;
             end
           end
        default: ;
      endcase
      m_cfg = m_mode == 3 ? bus.cfg_in : '0;
    end
  end

  function automatic logic [3:0] m_ring();
    return 4'((32'd1 << m_k) - 1);
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at edge %0d: got %h expected %h", nm, e, got, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("ring_en", 32'(bus.ring_en), 32'(m_ring()));
    chk("iso", 32'(bus.iso), 32'(m_mode != 3));
    chk("ready", 32'(bus.ready), 32'(m_mode == 3));
    chk("busy", 32'(bus.busy), 32'(m_mode == 1 || m_mode == 2 || m_mode == 4));
    chk("cfg", 32'(bus.cfg), 32'(m_cfg));
  end

  task automatic goto(input int x);
    while (e < x) @(negedge clk);
  endtask

  task automatic lit(input string nm, input logic [3:0] ring, input logic iso, input logic ready, input logic busy);
    chk({nm, "_ring"}, 32'(bus.ring_en), 32'(ring));
    chk({nm, "_model_ring"}, 32'(m_ring()), 32'(ring));
    chk({nm, "_iso"}, 32'(bus.iso), 32'(iso));
    chk({nm, "_ready"}, 32'(bus.ready), 32'(ready));
    chk({nm, "_busy"}, 32'(bus.busy), 32'(busy));
  endtask

  initial begin
    bus.en = 1'b0;
    bus.dly = 8'd2;
    bus.cfg_in = 16'hA5C3;
    #1 nreset = 1'b0;
    goto(2);
    lit("rst", 4'b0000, 1, 0, 0);
    chk("rst_cfg", 32'(bus.cfg), 32'h0);
    nreset = 1'b1;
    goto(5); lit("idle", 4'b0000, 1, 0, 0);
    goto(9); bus.en = 1'b1;
    goto(10); lit("up10", 4'b0000, 1, 0, 1);
    goto(12); lit("up12", 4'b0000, 1, 0, 1);
    goto(13); lit("up13", 4'b0001, 1, 0, 1);
    goto(16); lit("up16", 4'b0011, 1, 0, 1);
    goto(19); lit("up19", 4'b0111, 1, 0, 1);
    goto(22); lit("up22", 4'b1111, 1, 0, 1);
    goto(24); lit("up24", 4'b1111, 1, 0, 1);
    goto(25); lit("on25", 4'b1111, 0, 1, 0);
    chk("on25_cfg", 32'(bus.cfg), 32'hA5C3);
    goto(30); bus.cfg_in = 16'h1234;
    chk("on30_cfg", 32'(bus.cfg), 32'hA5C3);
    goto(31); chk("on31_cfg", 32'(bus.cfg), 32'h1234);
    goto(39); bus.en = 1'b0;
    goto(40); lit("dn40", 4'b1111, 1, 0, 1);
    chk("dn40_cfg", 32'(bus.cfg), 32'h0);
    goto(43); lit("dn43", 4'b0111, 1, 0, 1);
    goto(46); lit("dn46", 4'b0011, 1, 0, 1);
    goto(49); lit("dn49", 4'b0001, 1, 0, 1);
    goto(51); lit("dn51", 4'b0001, 1, 0, 1);
    goto(52); lit("dn52", 4'b0000, 1, 0, 0);
    goto(59); bus.en = 1'b1;
    goto(63); lit("ab63", 4'b0001, 1, 0, 1);
    goto(66); lit("ab66", 4'b0011, 1, 0, 1); bus.en = 1'b0;
    goto(67); lit("ab67", 4'b0011, 1, 0, 1);
    goto(70); lit("ab70", 4'b0001, 1, 0, 1); bus.en = 1'b1;
    goto(72); lit("ab72", 4'b0001, 1, 0, 1);
    goto(73); lit("ab73", 4'b0000, 1, 0, 0);
    goto(74); lit("ab74", 4'b0000, 1, 0, 1);
    goto(77); lit("ab77", 4'b0001, 1, 0, 1);
    goto(89); lit("ab89", 4'b1111, 0, 1, 0);
    goto(94); bus.en = 1'b0;
    goto(107); lit("ab107", 4'b0000, 1, 0, 0);
    goto(109); bus.dly = 8'd0; bus.en = 1'b1;
    goto(110); lit("z110", 4'b0000, 1, 0, 1);
    goto(111); lit("z111", 4'b0001, 1, 0, 1);
    goto(114); lit("z114", 4'b1111, 1, 0, 1);
    goto(115); lit("z115", 4'b1111, 0, 1, 0);
    goto(116); bus.en = 1'b0;
    goto(117); lit("z117", 4'b1111, 1, 0, 1);
    goto(120); lit("z120", 4'b0001, 1, 0, 1);
    goto(121); lit("z121", 4'b0000, 1, 0, 0);
    goto(129); bus.dly = 8'd2; bus.en = 1'b1;
    goto(131); bus.dly = 8'd5;
    goto(133); lit("d133", 4'b0001, 1, 0, 1);
    goto(138); lit("d138", 4'b0001, 1, 0, 1);
    goto(139); lit("d139", 4'b0011, 1, 0, 1);
    goto(146); lit("d146", 4'b0111, 1, 0, 1);
    #2 nreset = 1'b0;
    #1 lit("arst", 4'b0000, 1, 0, 0);
    chk("arst_cfg", 32'(bus.cfg), 32'h0);
    @(negedge clk) nreset = 1'b1;
    goto(153); lit("re153", 4'b0000, 1, 0, 1);
    goto(154); lit("re154", 4'b0001, 1, 0, 1);
    goto(160);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
